// File: rtl/load_store_unit_pkg.sv
// ============================================================================
// lsu_pkg : shared memory-type codes, FSM state type and helpers for the LSU
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  function automatic logic is_legal_mem_type(input logic [2:0] t);
    return (t == MEM_B) || (t == MEM_H) || (t == MEM_W) ||
           (t == MEM_BU) || (t == MEM_HU);
  endfunction

  // Expands per-lane byte enables into a 32-bit data mask.
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_load_align.sv
// ============================================================================
// lsu_load_align : selects the addressed byte/halfword of a read word and
//                  sign- or zero-extends it to 32 bits (purely combinational)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  mem_type,
  output logic [31:0] result
);
  import lsu_pkg::*;

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_shifted = rdata >> {off, 3'b000};
    w_byte    = w_shifted[7:0];
    w_half    = off[1] ? rdata[31:16] : rdata[15:0];
    case (mem_type)
      MEM_B:   result = {{24{w_byte[7]}}, w_byte};
      MEM_BU:  result = {24'h0, w_byte};
      MEM_H:   result = {{16{w_half[15]}}, w_half};
      MEM_HU:  result = {16'h0, w_half};
      default: result = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit : turns a pipeline load/store into one valid/ready data-bus
//                   transaction, stalling until the response or a fault.
// Optional macro  : LSU_MISALIGN_TRAP_EN - fault misaligned H/HU/W accesses
//                   instead of masking the low address bits.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        mem_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              done,
  output logic              fault,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);
  import lsu_pkg::*;

  // Counter only has to reach TIMEOUT_CYCLES-1; the last RESP cycle is the limit.
  localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_limit =
      (TIMEOUT_CYCLES > 0) ? c_cnt_w'(TIMEOUT_CYCLES - 1) : '0;

  lsu_state_t         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [1:0]         r_off;
  logic [2:0]         r_type;

  logic        w_req;
  logic        w_misalign;
  logic        w_illegal;
  logic [1:0]  w_off;
  logic [3:0]  w_be_store;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ext;

  assign w_req = mem_read | mem_write;

  always_comb begin
    w_misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((mem_type == MEM_H) || (mem_type == MEM_HU))
      w_misalign = addr[0];
    else if (mem_type == MEM_W)
      w_misalign = (addr[1:0] != 2'b00);
`endif
    w_illegal = (mem_read & mem_write) | ~is_legal_mem_type(mem_type) | w_misalign;
  end

  // Low address bits that cannot be honoured for the access size are masked.
  always_comb begin
    case (mem_type)
      MEM_H, MEM_HU: begin
        w_off      = {addr[1], 1'b0};
        w_be_store = 4'b0011 << w_off;
      end
      MEM_W: begin
        w_off      = 2'b00;
        w_be_store = 4'b1111;
      end
      default: begin
        w_off      = addr[1:0];
        w_be_store = 4'b0001 << w_off;
      end
    endcase
    // Reads always fetch the whole word; lane selection happens on return.
    w_be    = mem_read ? 4'b1111 : w_be_store;
    w_wdata = mem_read ? 32'h0 : ((store_data << {w_off, 3'b000}) & be_to_mask(w_be_store));
  end

  lsu_load_align u_load_align (
    .rdata    (bus_rdata),
    .off      (r_off),
    .mem_type (r_type),
    .result   (w_ext)
  );

  assign stall = (r_state == REQ) || (r_state == RESP) || ((r_state == IDLE) && w_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_off     <= 2'b00;
      r_type    <= MEM_B;
      load_data <= 32'h0;
      done      <= 1'b0;
      fault     <= 1'b0;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= 4'h0;
      bus_wdata <= 32'h0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if (w_illegal) begin
              r_state <= DONE;
              done    <= 1'b1;
              fault   <= 1'b1;
            end else begin
              r_state   <= REQ;
              r_off     <= w_off;
              r_type    <= mem_type;
              bus_valid <= 1'b1;
              bus_we    <= mem_write;
              bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
              bus_be    <= w_be;
              bus_wdata <= w_wdata;
            end
          end
        end
        REQ: begin
          if (bus_valid && bus_ready) begin
            bus_valid <= 1'b0;
            r_cnt     <= '0;
            r_state   <= RESP;
          end
        end
        RESP: begin
          r_cnt <= r_cnt + c_cnt_w'(1);
          if (bus_rvalid) begin
            if (!bus_we)
              load_data <= w_ext;
            r_state <= DONE;
            done    <= 1'b1;
          end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == c_cnt_limit)) begin
            r_state <= DONE;
            done    <= 1'b1;
            fault   <= 1'b1;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// tb_load_store_unit : directed self-checking bench for load_store_unit
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_type;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic [31:0] load_data;
  logic        done;
  logic        fault;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int total;
  int bad;

  // Observations recorded by run_access
  int          o_stall;
  bit          o_valid, o_done, o_fault, o_unstable, o_we;
  logic [3:0]  o_be;
  logic [31:0] o_addr, o_wdata, o_ld;
  logic [31:0] exp_ld;

  load_store_unit #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_type   (mem_type),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .load_data  (load_data),
    .done       (done),
    .fault      (fault),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one access and acts as the bus slave; called and returns 1ns after a rising edge.
  // rdy_delay: valid cycles before ready; rv_delay: RESP cycles before rvalid (-1 = never).
  task automatic run_access(input bit rd, input bit wr, input logic [2:0] t,
                            input logic [31:0] a, input logic [31:0] sd,
                            input int rdy_delay, input int rv_delay,
                            input logic [31:0] rdat);
    int  vcyc, rcyc;
    bit  acc, acc_next;
    vcyc = 0; rcyc = 0; acc = 0; acc_next = 0;
    o_stall = 0; o_valid = 0; o_done = 0; o_fault = 0; o_unstable = 0;
    o_we = 0; o_be = '0; o_addr = '0; o_wdata = '0; o_ld = '0;
    mem_read = rd; mem_write = wr; mem_type = t; addr = a; store_data = sd;
    bus_rdata = rdat; bus_ready = 1'b0; bus_rvalid = 1'b0;
    #0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        o_done = 1; o_fault = fault; o_ld = load_data;
        break;
      end
      if (stall) o_stall++;
      bus_ready = 1'b0; bus_rvalid = 1'b0;
      if (acc) begin
        if (rv_delay >= 0 && rcyc >= rv_delay) bus_rvalid = 1'b1;
        rcyc++;
      end
      if (bus_valid) begin
        if (vcyc == 0) begin
          o_valid = 1; o_we = bus_we; o_be = bus_be; o_addr = bus_addr; o_wdata = bus_wdata;
        end else if (bus_we !== o_we || bus_be !== o_be || bus_addr !== o_addr || bus_wdata !== o_wdata) begin
          o_unstable = 1;
        end
        if (vcyc >= rdy_delay) begin
          bus_ready = 1'b1;
          acc_next  = 1;
        end
        vcyc++;
      end
      @(posedge clk); #1;
      if (acc_next) acc = 1;
    end
    mem_read = 1'b0; mem_write = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    total++; if (bus_valid !== 1'b0) begin bad++; $display("FAIL reset_bus_valid: got %b want 0", bus_valid); end
    total++; if (done !== 1'b0 || fault !== 1'b0) begin bad++; $display("FAIL reset_done_fault: got %b%b want 00", done, fault); end
    total++; if (load_data !== 32'h0) begin bad++; $display("FAIL reset_load_data: got %h want 0", load_data); end
    total++; if ({bus_we, bus_be, bus_addr, bus_wdata} !== 69'h0) begin bad++; $display("FAIL reset_bus_fields: got we=%b be=%b addr=%h wdata=%h want all 0", bus_we, bus_be, bus_addr, bus_wdata); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
  endtask

  task automatic test_lw();
    run_access(1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
    total++; if (!o_done || o_fault) begin bad++; $display("FAIL lw_done: got done=%b fault=%b want 1 0", o_done, o_fault); end
    total++; if (o_be !== 4'b1111 || o_addr !== 32'h100 || o_we !== 1'b0) begin bad++; $display("FAIL lw_bus: got be=%b addr=%h we=%b want 1111 00000100 0", o_be, o_addr, o_we); end
    total++; if (o_stall != 3) begin bad++; $display("FAIL lw_stall_cycles: got %0d want 3", o_stall); end
    total++; if (o_ld !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data: got %h want deadbeef", o_ld); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL lw_done_pulse: got %b want 0", done); end
    exp_ld = 32'hDEADBEEF;
  endtask

  task automatic test_byte_loads();
    run_access(1, 0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF1234);
    total++; if (o_be !== 4'b1111 || o_addr !== 32'h100) begin bad++; $display("FAIL lb_bus: got be=%b addr=%h want 1111 00000100", o_be, o_addr); end
    total++; if (o_ld !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_data: got %h want ffffff80", o_ld); end
    run_access(1, 0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80FF1234);
    total++; if (o_ld !== 32'h00000080) begin bad++; $display("FAIL lbu_data: got %h want 00000080", o_ld); end
    run_access(1, 0, 3'b000, 32'h101, 32'h0, 0, 0, 32'h80FF1234);
    total++; if (o_ld !== 32'h00000012) begin bad++; $display("FAIL lb_pos_data: got %h want 00000012", o_ld); end
    exp_ld = 32'h00000012;
  endtask

  task automatic test_half_loads();
    run_access(1, 0, 3'b001, 32'h102, 32'h0, 0, 0, 32'h80017FFF);
    total++; if (o_ld !== 32'hFFFF8001) begin bad++; $display("FAIL lh_data: got %h want ffff8001", o_ld); end
    run_access(1, 0, 3'b101, 32'h102, 32'h0, 0, 0, 32'h80017FFF);
    total++; if (o_ld !== 32'h00008001) begin bad++; $display("FAIL lhu_data: got %h want 00008001", o_ld); end
    run_access(1, 0, 3'b001, 32'h100, 32'h0, 0, 0, 32'h80017FFF);
    total++; if (o_ld !== 32'h00007FFF) begin bad++; $display("FAIL lh_low_data: got %h want 00007fff", o_ld); end
    exp_ld = 32'h00007FFF;
  endtask

  task automatic test_stores();
    run_access(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 4, 0, 32'h0);
    total++; if (o_we !== 1'b1 || o_be !== 4'b1100 || o_wdata !== 32'hABCD0000 || o_addr !== 32'h200) begin bad++; $display("FAIL sh_bus: got we=%b be=%b wdata=%h addr=%h want 1 1100 abcd0000 00000200", o_we, o_be, o_wdata, o_addr); end
    total++; if (o_unstable) begin bad++; $display("FAIL sh_hold_stable: got changed fields want stable"); end
    total++; if (o_stall != 7) begin bad++; $display("FAIL sh_stall_cycles: got %0d want 7", o_stall); end
    total++; if (!o_done || o_fault || o_ld !== exp_ld) begin bad++; $display("FAIL sh_done_ld: got done=%b fault=%b ld=%h want 1 0 %h", o_done, o_fault, o_ld, exp_ld); end
    run_access(0, 1, 3'b000, 32'h201, 32'h12345678, 0, 0, 32'h0);
    total++; if (o_be !== 4'b0010 || o_wdata !== 32'h00007800 || o_addr !== 32'h200) begin bad++; $display("FAIL sb_bus: got be=%b wdata=%h addr=%h want 0010 00007800 00000200", o_be, o_wdata, o_addr); end
    run_access(0, 1, 3'b010, 32'h204, 32'hA5A50F0F, 1, 2, 32'h0);
    total++; if (o_be !== 4'b1111 || o_wdata !== 32'hA5A50F0F || o_addr !== 32'h204 || !o_done) begin bad++; $display("FAIL sw_bus: got be=%b wdata=%h addr=%h done=%b want 1111 a5a50f0f 00000204 1", o_be, o_wdata, o_addr, o_done); end
  endtask

  task automatic test_misalign();
    run_access(1, 0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h11223344);
`ifdef LSU_MISALIGN_TRAP_EN
    total++; if (o_valid || !o_done || !o_fault || o_stall != 1) begin bad++; $display("FAIL misalign_trap: got valid=%b done=%b fault=%b stall=%0d want 0 1 1 1", o_valid, o_done, o_fault, o_stall); end
    total++; if (o_ld !== exp_ld) begin bad++; $display("FAIL misalign_ld: got %h want %h", o_ld, exp_ld); end
`else
    total++; if (!o_valid || o_addr !== 32'h100 || o_be !== 4'b1111 || o_fault || !o_done) begin bad++; $display("FAIL misalign_mask: got valid=%b addr=%h be=%b fault=%b done=%b want 1 00000100 1111 0 1", o_valid, o_addr, o_be, o_fault, o_done); end
    total++; if (o_ld !== 32'h11223344) begin bad++; $display("FAIL misalign_ld: got %h want 11223344", o_ld); end
    exp_ld = 32'h11223344;
`endif
  endtask

  task automatic test_faults();
    run_access(1, 0, 3'b001, 32'h300, 32'h0, 0, -1, 32'hFFFFFFFF);
    total++; if (!o_done || !o_fault) begin bad++; $display("FAIL timeout_fault: got done=%b fault=%b want 1 1", o_done, o_fault); end
    total++; if (o_stall != 6) begin bad++; $display("FAIL timeout_stall: got %0d want 6", o_stall); end
    total++; if (o_ld !== exp_ld) begin bad++; $display("FAIL timeout_ld: got %h want %h", o_ld, exp_ld); end
    run_access(1, 0, 3'b011, 32'h300, 32'h0, 0, 0, 32'h0);
    total++; if (o_valid || !o_fault || !o_done || o_stall != 1) begin bad++; $display("FAIL bad_type: got valid=%b fault=%b done=%b stall=%0d want 0 1 1 1", o_valid, o_fault, o_done, o_stall); end
    run_access(1, 1, 3'b010, 32'h300, 32'h0, 0, 0, 32'h0);
    total++; if (o_valid || !o_fault || o_ld !== exp_ld) begin bad++; $display("FAIL rd_wr_both: got valid=%b fault=%b ld=%h want 0 1 %h", o_valid, o_fault, o_ld, exp_ld); end
    total++; if (fault !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL fault_pulse: got done=%b fault=%b want 0 0", done, fault); end
  endtask

  task automatic test_reset_mid();
    mem_read = 1'b1; mem_write = 1'b0; mem_type = 3'b010; addr = 32'h300;
    bus_ready = 1'b1; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_ready = 1'b0; mem_read = 1'b0; rst_n = 1'b0;
    #1;
    total++; if (bus_valid !== 1'b0 || bus_be !== 4'h0 || bus_addr !== 32'h0 || load_data !== 32'h0 || stall !== 1'b0) begin bad++; $display("FAIL reset_mid: got valid=%b be=%b addr=%h ld=%h stall=%b want all 0", bus_valid, bus_be, bus_addr, load_data, stall); end
    @(posedge clk); #1;
    rst_n = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    total++; if (done !== 1'b0 || load_data !== 32'h0 || bus_valid !== 1'b0) begin bad++; $display("FAIL stray_rvalid: got done=%b ld=%h valid=%b want 0 0 0", done, load_data, bus_valid); end
    run_access(1, 0, 3'b010, 32'h104, 32'h0, 0, 0, 32'hCAFEF00D);
    total++; if (!o_done || o_fault || o_ld !== 32'hCAFEF00D || o_stall != 3) begin bad++; $display("FAIL post_reset_lw: got done=%b fault=%b ld=%h stall=%0d want 1 0 cafef00d 3", o_done, o_fault, o_ld, o_stall); end
  endtask

  initial begin
    total = 0; bad = 0; exp_ld = 32'h0;
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_type = 3'b000;
    addr = 32'h0; store_data = 32'h0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_lw();
    test_byte_loads();
    test_half_loads();
    test_stores();
    test_misalign();
    test_faults();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Responder to the decode stage's memory controls: mem_read, mem_write and the 3-bit mem_type (funct3 of LOAD/STORE).
- Turns a pipeline memory request into a single valid/ready transaction on the data-memory bus, generating byte enables and lane-shifted store data.
- Returns sign/zero-extended load data and stalls the pipeline until the access completes.
- Sits between the execute-stage ALU address output and the data-memory port.

Parameters:
- TIMEOUT_CYCLES, 255, cycles to wait in RESP for bus_rvalid before faulting; 0 disables the timeout.
- ADDR_W, 32, byte-address width. Data width is fixed at 32 (4 byte lanes).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_read  in  1  load request, held stable while stall=1.
- mem_write  in  1  store request, held stable while stall=1.
- mem_type  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU. Other codes are illegal.
- addr  in  ADDR_W  byte address from the ALU.
- store_data  in  32  rs2 value.
- stall  out  1  pipeline hold.
- load_data  out  32  extended load result, registered.
- done  out  1  one-cycle pulse when an access completes or faults.
- fault  out  1  one-cycle pulse, coincident with done, when the access faults.
- bus_valid  out  1  request valid.
- bus_ready  in  1  request accepted.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  word-aligned address (addr with [1:0] forced to 00).
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-shifted store data.
- bus_rvalid  in  1  response valid; for a write this is the write acknowledge.
- bus_rdata  in  32  read word.

Behaviour:
- Reset (async, rst_n low): state=IDLE, timeout counter=0. All outputs are 0: load_data, done, fault, bus_valid, bus_we, bus_addr, bus_be, bus_wdata.
- States: IDLE, REQ, RESP, DONE.
- stall is combinational: 1 in REQ and RESP, and 1 in IDLE when (mem_read | mem_write). It is 0 in DONE.
- IDLE:
  - A legal request registers addr, mem_type, direction and store data, computes bus_be/bus_wdata, and moves to REQ.
  - An illegal request moves directly to DONE with fault pending and makes no bus access.
  - An illegal request is any of: illegal mem_type, mem_read&mem_write both high, or a misaligned access (see Optional Feature).
- REQ: bus_valid=1; bus fields are held constant. On bus_valid&bus_ready, go to RESP and clear the counter. bus_valid must not drop before acceptance.
- RESP:
  - Wait for bus_rvalid. For a load, capture the extended bus_rdata into load_data, then go to DONE.
  - The counter increments each cycle. When TIMEOUT_CYCLES is nonzero and the counter reaches it, go to DONE with fault; load_data is unchanged.
- DONE: done=1, with fault=1 if pending; stall=0, so the pipeline advances this cycle. Next state is IDLE. The new instruction's request is sampled in IDLE on the following cycle.
- Minimum latency with immediate ready and rvalid: 3 stall cycles (IDLE, REQ, RESP), then DONE.
- Byte enables, using off=addr[1:0]:
  - B: 0001<<off
  - H: 0011<<off
  - W: 1111
- Store data: bus_wdata = store_data << (8*off), with unused lanes set to 0.
- Loads:
  - B/BU: extract byte lane off.
  - H/HU: extract halfword at off[1].
  - W: whole word.
  - B and H sign-extend; BU and HU zero-extend.
  - load_data holds its value across stores and faults.
- Edge cases:
  - bus_rvalid arriving in IDLE, REQ or DONE is ignored.
  - Reset mid-transaction drops bus_valid immediately. A later stray response is ignored.
  - mem_read/mem_write deasserting while stall=1 is a protocol violation; the access completes anyway.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: H/HU with addr[0]=1, or W with addr[1:0]!=00, is faulted in IDLE with no bus access, going IDLE to DONE with done=1 and fault=1.
- Undefined: the offending low address bits are masked before lane selection (H uses off & 2'b10, W uses off 00) and the access proceeds normally. fault is raised only for illegal types or timeout.

Decomposition:
- Shared package lsu_pkg holds:
  - mem_type localparams: MEM_B=3'b000, MEM_H=3'b001, MEM_W=3'b010, MEM_BU=3'b100, MEM_HU=3'b101.
  - The lsu_state_t enum (IDLE, REQ, RESP, DONE).
  - An is_legal_mem_type function.
- One sub-module: lsu_load_align, purely combinational (rdata, off, mem_type -> extended 32-bit result). It is reused by the verification model.

Test Plan:
1. LW addr=0x100, bus_ready and bus_rvalid same cycle as offered, rdata=0xDEADBEEF -> bus_be=1111, bus_addr=0x100, 3 stall cycles, done pulse, load_data=0xDEADBEEF.
2. LB addr=0x103, rdata=0x80FF_1234 -> bus_be=1111 on read, load_data=0xFFFFFF80. Same access as LBU -> load_data=0x00000080.
3. SH addr=0x202, store_data=0x0000ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCD0000, bus_addr=0x200. bus_ready held 0 for 4 cycles -> bus_valid and fields stable throughout, stall held.
4. LW addr=0x101 with LSU_MISALIGN_TRAP_EN -> no bus_valid, done=1 and fault=1 on the 2nd cycle. Without the macro -> read of 0x100, bus_be=1111, no fault.
5. TIMEOUT_CYCLES=4, LH with bus_rvalid never asserted -> fault and done after 4 RESP cycles, load_data unchanged. mem_type=3'b011 -> immediate fault, no bus access.
6. rst_n low in RESP, then a stray bus_rvalid after reset -> all outputs 0, state IDLE, stray response ignored, next LW completes normally.
